// File: rtl/i2c_target_model_if.sv
// I2C bus bundle between the controller side (drives the resolved SCL/SDA
// levels) and the target side (pulls SDA low through sda_en_o).
interface i2c_target_model_if;
  logic scl_i;
  logic sda_i;
  logic sda_en_o;

  modport master (output scl_i, output sda_i, input sda_en_o);
  modport slave  (input scl_i, input sda_i, output sda_en_o);
endinterface

// File: rtl/i2c_target_model.sv
// EEPROM-style I2C target: the first write byte sets a register pointer,
// further bytes write or read an 8-bit register file with auto-increment.
module i2c_target_model #(
  parameter logic [6:0] TargetAddr = 7'h50,
  parameter int         NumRegs    = 16,
  parameter logic [7:0] ResetFill  = 8'h00
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  i2c_target_model_if.slave          bus,
  output logic                       busy_o,
  // wr_pulse_o is a valid-only strobe with no ready: the consumer takes
  // wr_addr_o/wr_data_o in the pulse cycle; both hold until the next write.
  output logic                       wr_pulse_o,
  output logic [$clog2(NumRegs)-1:0] wr_addr_o,
  output logic [7:0]                 wr_data_o,
  output logic [2:0]                 dbg_state_o
);

  localparam int PtrW = $clog2(NumRegs);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX_PTR   = 3'd3,
    RX_DATA  = 3'd4,
    RX_ACK   = 3'd5,
    TX       = 3'd6,
    TX_ACK   = 3'd7
  } state_t;

  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_h  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_s1 <= bus.scl_i;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= bus.sda_i;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [7:0]        shift;
  logic              rw;
  logic [PtrW-1:0]   pointer;
  logic [7:0]        regs [NumRegs];
  logic              sda_en;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      rw         <= 1'b0;
      pointer    <= '0;
      sda_en     <= 1'b0;
      busy_o     <= 1'b0;
      wr_pulse_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= 8'h00;
      for (int i = 0; i < NumRegs; i++) regs[i] <= ResetFill;
    end else begin
      wr_pulse_o <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_en  <= 1'b0;
        busy_o  <= 1'b1;
      end else if (stop_det) begin
        state  <= IDLE;
        busy_o <= 1'b0;
        sda_en <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR, RX_PTR, RX_DATA: begin
            // The SCL fall right after START arrives with bit_cnt=0 and is ignored.
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (state == ADDR) begin
                if (shift[7:1] == TargetAddr) begin
                  rw     <= shift[0];
                  sda_en <= 1'b1;
                  state  <= ADDR_ACK;
                end else begin
                  state <= IDLE;
                end
              end else if (state == RX_PTR) begin
                pointer <= shift[PtrW-1:0];
                sda_en  <= 1'b1;
                state   <= RX_ACK;
              end else begin
                regs[pointer] <= shift;
                wr_pulse_o    <= 1'b1;
                wr_addr_o     <= pointer;
                wr_data_o     <= shift;
                pointer       <= pointer + 1'b1;
                sda_en        <= 1'b1;
                state         <= RX_ACK;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                shift   <= regs[pointer];
                sda_en  <= ~regs[pointer][7];
                bit_cnt <= 4'd1;
                state   <= TX;
              end else begin
                sda_en <= 1'b0;
                state  <= RX_PTR;
              end
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              sda_en <= 1'b0;
              state  <= RX_DATA;
            end
          end
          TX: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_en <= 1'b0;
                state  <= TX_ACK;
              end else begin
                shift   <= {shift[6:0], 1'b0};
                sda_en  <= ~shift[6];
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          TX_ACK: begin
            // Every byte handed out advances the pointer, including the NACKed
            // last one, so a follow-up current-address read continues after it.
            if (scl_rise) begin
              pointer <= pointer + 1'b1;
              if (sda_s2) state <= IDLE;
            end else if (scl_fall) begin
              shift   <= regs[pointer];
              sda_en  <= ~regs[pointer][7];
              bit_cnt <= 4'd1;
              state   <= TX;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sda_en_o = sda_en;
  assign dbg_state_o  = state;

endmodule

// File: tb/tb_i2c_target_model.sv
// Bench for i2c_target_model: a bit-banged controller at SCL = clk/64, a
// register-file model, and queues of expected write strobes and read bytes.
module tb_i2c_target_model;

  localparam int PW = 4;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;

  logic          busy_o, wr_pulse_o;
  logic [PW-1:0] wr_addr_o;
  logic [7:0]    wr_data_o;
  logic [2:0]    dbg_state_o;

  i2c_target_model_if bus ();

  assign bus.scl_i = scl_drv;
  assign bus.sda_i = sda_drv & ~bus.sda_en_o;

  i2c_target_model #(.TargetAddr(7'h50), .NumRegs(16), .ResetFill(8'h00)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .busy_o      (busy_o),
    .wr_pulse_o  (wr_pulse_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- scoreboard state ----------------
  logic [PW+7:0] exp_q[$];
  logic [7:0]    rd_q[$];
  logic [7:0]    mdl [16];
  logic [PW-1:0] tb_ptr;

  logic tb_scl_s1, tb_scl_s2, scl_s2_prev, en_prev;
  logic sda_seen;
  int   viol = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_scl_s1 <= 1'b1;
      tb_scl_s2 <= 1'b1;
    end else begin
      tb_scl_s1 <= bus.scl_i;
      tb_scl_s2 <= tb_scl_s1;
    end
  end

  // Write-strobe checker plus the "SDA moves only while SCL is low" watch.
  always @(negedge clk) begin
    logic [PW+7:0] e;
    if (!rst) begin
      if (wr_pulse_o === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL wr_pulse: got unexpected write addr=%0d data=%02h, required none",
                   wr_addr_o, wr_data_o);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr_o, wr_data_o} !== e) begin
            bad++;
            $display("FAIL wr_pulse: got addr=%0d data=%02h, required addr=%0d data=%02h",
                     wr_addr_o, wr_data_o, e[PW+7:8], e[7:0]);
          end
        end
      end
      if (bus.sda_en_o !== en_prev && (tb_scl_s2 || scl_s2_prev)) viol++;
      if (bus.sda_en_o === 1'b1) sda_seen = 1'b1;
    end
    en_prev     = bus.sda_en_o;
    scl_s2_prev = tb_scl_s2;
  end

  // ---------------- driver tasks ----------------
  task automatic quarter();
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    sda_drv = 1'b1; quarter();
    scl_drv = 1'b1; quarter();
    sda_drv = 1'b0; quarter();
    scl_drv = 1'b0; quarter();
  endtask

  task automatic send_stop();
    sda_drv = 1'b0; quarter();
    scl_drv = 1'b1; quarter();
    sda_drv = 1'b1; quarter();
    quarter();
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_drv = b; quarter();
    scl_drv = 1'b1; quarter();
    s = bus.sda_i; quarter();
    scl_drv = 1'b0; quarter();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clock_bit(~m_ack, s);
  endtask

  task automatic do_write(input logic [7:0] ptr, input int n, input logic [7:0] d[8],
                          output logic [9:0] acks);
    logic a;
    acks = '0;
    send_start();
    write_byte(8'hA0, a); acks[0] = a;
    write_byte(ptr, a);   acks[1] = a;
    tb_ptr = ptr[PW-1:0];
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({tb_ptr, d[i]});
      mdl[tb_ptr] = d[i];
      tb_ptr = tb_ptr + 1'b1;
      write_byte(d[i], a); acks[2+i] = a;
    end
    send_stop();
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] ptr, input int n,
                         output logic [7:0] got[8], output logic [9:0] acks);
    logic a;
    int   k;
    acks = '0;
    k = 0;
    send_start();
    if (set_ptr) begin
      write_byte(8'hA0, a); acks[0] = a;
      write_byte(ptr, a);   acks[1] = a;
      tb_ptr = ptr[PW-1:0];
      k = 2;
      send_start();
    end
    write_byte(8'hA1, a); acks[k] = a;
    for (int i = 0; i < n; i++) begin
      rd_q.push_back(mdl[tb_ptr]);
      tb_ptr = tb_ptr + 1'b1;
      read_byte(i != n - 1, got[i]);
    end
    send_stop();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if (bus.sda_en_o !== 1'b0) begin bad++; $display("FAIL reset_sda_en: got %b required 0", bus.sda_en_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    total++; if (wr_pulse_o !== 1'b0) begin bad++; $display("FAIL reset_wr_pulse: got %b required 0", wr_pulse_o); end
    total++; if (wr_addr_o !== '0) begin bad++; $display("FAIL reset_wr_addr: got %0d required 0", wr_addr_o); end
    total++; if (wr_data_o !== 8'h00) begin bad++; $display("FAIL reset_wr_data: got %02h required 00", wr_data_o); end
    total++; if (dbg_state_o !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d required 0", dbg_state_o); end
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    tb_ptr = '0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    quarter();
  endtask

  task automatic test_write();
    logic [7:0] d[8];
    logic [9:0] acks;
    d[0] = 8'h11; d[1] = 8'h22;
    do_write(8'h03, 2, d, acks);
    total++; if (acks[3:0] !== 4'hF) begin bad++; $display("FAIL write_acks: got %b required 1111", acks[3:0]); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL write_busy_after_stop: got %b required 0", busy_o); end
    total++; if ({wr_addr_o, wr_data_o} !== {4'd4, 8'h22}) begin bad++; $display("FAIL write_last_held: got %0d/%02h required 4/22", wr_addr_o, wr_data_o); end
  endtask

  task automatic test_combined_read();
    logic [7:0] d[8];
    logic [7:0] got[8];
    logic [7:0] e;
    logic [9:0] acks;
    d[0] = 8'h55;
    do_write(8'h05, 1, d, acks);
    do_read(1'b1, 8'h03, 2, got, acks);
    total++; if (acks[2:0] !== 3'b111) begin bad++; $display("FAIL rd_acks: got %b required 111", acks[2:0]); end
    for (int i = 0; i < 2; i++) begin
      e = rd_q.pop_front();
      total++; if (got[i] !== e) begin bad++; $display("FAIL rd_byte%0d: got %02h required %02h", i, got[i], e); end
    end
    total++; if (bus.sda_en_o !== 1'b0) begin bad++; $display("FAIL rd_sda_released: got %b required 0", bus.sda_en_o); end
    do_read(1'b0, 8'h00, 1, got, acks);
    e = rd_q.pop_front();
    total++; if (got[0] !== e) begin bad++; $display("FAIL rd_current_addr: got %02h required %02h", got[0], e); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    send_start();
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL wa_busy_start: got %b required 1", busy_o); end
    sda_seen = 1'b0;
    write_byte(8'hB0, a0);
    write_byte(8'h55, a1);
    send_stop();
    total++; if ({a0, a1} !== 2'b00) begin bad++; $display("FAIL wa_acks: got %b required 00", {a0, a1}); end
    total++; if (sda_seen !== 1'b0) begin bad++; $display("FAIL wa_sda_en: got %b required 0", sda_seen); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL wa_busy_stop: got %b required 0", busy_o); end
  endtask

  task automatic test_wrap();
    logic [7:0] d[8];
    logic [7:0] got[8];
    logic [7:0] e;
    logic [9:0] acks;
    d[0] = 8'hAA; d[1] = 8'hBB;
    do_write(8'h0F, 2, d, acks);
    total++; if (acks[3:0] !== 4'hF) begin bad++; $display("FAIL wrap_acks: got %b required 1111", acks[3:0]); end
    do_read(1'b1, 8'h0F, 2, got, acks);
    for (int i = 0; i < 2; i++) begin
      e = rd_q.pop_front();
      total++; if (got[i] !== e) begin bad++; $display("FAIL wrap_rd%0d: got %02h required %02h", i, got[i], e); end
    end
    d[0] = 8'h77;
    do_write(8'h13, 1, d, acks);
    total++; if (wr_addr_o !== 4'd3) begin bad++; $display("FAIL wrap_ptr_mod: got %0d required 3", wr_addr_o); end
  endtask

  task automatic test_abort_stop();
    logic a, s;
    send_start();
    write_byte(8'hA0, a);
    write_byte(8'h02, a);
    tb_ptr = 4'd2;
    for (int i = 0; i < 4; i++) clock_bit(i[0], s);
    send_stop();
    total++; if (bus.sda_en_o !== 1'b0) begin bad++; $display("FAIL abort_sda_en: got %b required 0", bus.sda_en_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b required 0", busy_o); end
    total++; if (dbg_state_o !== ST_IDLE) begin bad++; $display("FAIL abort_state: got %0d required 0", dbg_state_o); end
  endtask

  task automatic test_reset_mid_ack();
    logic s;
    logic [7:0] got[8];
    logic [7:0] e;
    logic [9:0] acks;
    logic [7:0] a0;
    a0 = 8'hA0;
    send_start();
    for (int i = 7; i >= 0; i--) clock_bit(a0[i], s);
    sda_drv = 1'b1;
    quarter();
    total++; if (bus.sda_en_o !== 1'b1) begin bad++; $display("FAIL rst_ack_driven: got %b required 1", bus.sda_en_o); end
    rst = 1'b1;
    #1;
    total++; if (bus.sda_en_o !== 1'b0) begin bad++; $display("FAIL rst_sda_en: got %b required 0", bus.sda_en_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy_o); end
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    tb_ptr = '0;
    scl_drv = 1'b1; sda_drv = 1'b1;
    quarter();
    rst = 1'b0;
    quarter();
    do_read(1'b0, 8'h00, 5, got, acks);
    for (int i = 0; i < 5; i++) begin
      e = rd_q.pop_front();
      total++; if (got[i] !== e) begin bad++; $display("FAIL rst_fill%0d: got %02h required %02h", i, got[i], e); end
    end
    do_read(1'b1, 8'h0F, 1, got, acks);
    e = rd_q.pop_front();
    total++; if (got[0] !== e) begin bad++; $display("FAIL rst_fill15: got %02h required %02h", got[0], e); end
  endtask

  task automatic test_random();
    logic [7:0] d[8];
    logic [7:0] got[8];
    logic [7:0] p, e;
    logic [9:0] acks;
    int n;
    for (int it = 0; it < 3; it++) begin
      p = 8'($urandom_range(0, 15));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) d[i] = 8'($urandom_range(0, 255));
      do_write(p, n, d, acks);
      total++; if (acks !== 10'((1 << (n + 2)) - 1)) begin bad++; $display("FAIL rand_wr_acks%0d: got %b", it, acks); end
      do_read(1'b1, p, n, got, acks);
      for (int i = 0; i < n; i++) begin
        e = rd_q.pop_front();
        total++; if (got[i] !== e) begin bad++; $display("FAIL rand_rd%0d_%0d: got %02h required %02h", it, i, got[i], e); end
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_write();
    test_combined_read();
    test_wrong_addr();
    test_wrap();
    test_abort_stop();
    test_reset_mid_ack();
    test_random();
    quarter();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wr_missing: got %0d pending writes required 0", exp_q.size()); end
    total++; if (viol != 0) begin bad++; $display("FAIL sda_en_scl_high: got %0d toggles required 0", viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
